board_panel_ctrl: RTL and testbench
===================================

# board_panel_ctrl

Parametrised board front-panel controller sitting between the 50 MHz board clock domain and the DE2 switch/LED/seven-segment pins. Synchronises and debounces up to NUM_SW slide switches, produces one-cycle rising-edge pulses, and drives NUM_DIGITS active-low hex seven-segment displays from a loadable value register. It also drives the red LEDs (debounced switch mirror) and the green LEDs (edge counter and heartbeat). Used by every lab top level in place of ad-hoc switch/display glue.

## Interface

- NUM_SW, 18, switch count (1..18)
- NUM_DIGITS, 8, displays driven (1..8)
- SAMPLE_DIV, 50000, clock cycles per debounce sample tick (>=2; 1 ms at 50 MHz)
- STABLE_SAMPLES, 4, consecutive differing samples needed to flip a debounced switch (1..15)

- clock_50  in  1  board clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- switch  in  NUM_SW  raw asynchronous switch inputs
- display_value  in  4*NUM_DIGITS  hex value; nibble i feeds digit i
- display_load  in  1  capture display_value on this edge
- switch_db  out  NUM_SW  debounced switch levels
- switch_rise  out  NUM_SW  one-cycle pulse per debounced 0->1 transition
- seven_seg_n  out  7 x NUM_DIGITS (unpacked [NUM_DIGITS-1:0])  active-low segments; bit0=a ... bit6=g
- led_red  out  NUM_SW  equals switch_db
- led_green  out  9  [7:0] rising-edge event count, [8] heartbeat

## Operation

- Synchroniser: each switch bit passes through two flops before use.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps; sample_tick is asserted for exactly one cycle when the count equals SAMPLE_DIV-1.
- Debounce, per switch, evaluated only on sample_tick:
  - If the synchronised level differs from switch_db, the counter increments.
  - On reaching STABLE_SAMPLES, switch_db inverts and the counter clears.
  - If the level equals switch_db, the counter clears. A single agreeing sample therefore restarts the count.
- switch_rise[i] = 1 for the cycle after switch_db[i] goes 0->1. Falling transitions produce no pulse.
- Edge counter: 8-bit; increments by 1 in any cycle where switch_rise is nonzero, even if several bits are set; wraps 255->0.
- Heartbeat: led_green[8] toggles every 256 sample_ticks.
- Display register:
  - held_value loads display_value on any edge with display_load=1; otherwise it holds.
  - Digit i decodes nibble i as hex 0-F using the standard active-low patterns: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E.
- Reset (asynchronous, anytime, including mid-debounce):
  - All of the following go to 0: prescaler, counters, synchronisers, switch_db, switch_rise, held_value, led_red, led_green.
  - seven_seg_n shows '0' on every enabled digit (7'h40).
  - Any debounce in progress is discarded.

## Timing

- A change in held_value appears on seven_seg_n one cycle later: display_load at edge N gives new segments after edge N+1.
- Switch latency:
  - 2 cycles of synchronisation.
  - Then STABLE_SAMPLES sample_ticks of a stable level.
  - switch_db updates on the tick edge; switch_rise and the edge counter update on the following edge.
- The first sample_tick after reset release occurs SAMPLE_DIV cycles later.
- switch, switch_db, led_red, and led_green/seven_seg_n are all registered; no combinational path from inputs to outputs.

## Configuration

- Macro: BOARD_PANEL_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble of held_value output 7'h7F.
  - Digit 0 is never blanked, so a value of 0 shows a single '0'.
  - Reset state: digit 0 = 7'h40, all others 7'h7F.
- Undefined: all NUM_DIGITS digits are always decoded, leading zeros included.

## Test plan

- Reset, default parameters, macro undefined: hold resetn=0 -> all seven_seg_n = 7'h40, switch_db=0, led_green=0. Assert resetn=0 mid-operation -> same values, asynchronously.
- Display, NUM_DIGITS=8: display_load=1 with display_value=32'h0000_00A5 -> one cycle later digit0=7'h12 (5), digit1=7'h08 (A), digits 7..2 = 7'h40. With the macro defined, digits 7..2 = 7'h7F.
- Debounce pass, SAMPLE_DIV=4, STABLE_SAMPLES=3: hold switch[3]=1 -> switch_db[3] rises on the 3rd tick, switch_rise[3] is a single-cycle pulse, led_green[7:0]=1.
- Bounce rejection, same parameters: toggle switch[3] 1,1,0 across three ticks -> switch_db[3] stays 0; a following run of 3 ticks at 1 -> switch_db[3]=1.
- Simultaneous edges: switch[0] and switch[5] rise together -> both pulses in the same cycle, edge count +1. After 256 pulses the count wraps to 0.
- Heartbeat, SAMPLE_DIV=2: led_green[8] toggles every 512 cycles.

Source files
------------

// File: rtl/board_panel_ctrl.sv
// Front-panel glue: switch synchroniser/debouncer with rise pulses, edge counter,
// heartbeat, and a hex seven-segment driver. BOARD_PANEL_LZ_BLANK_EN enables leading-zero blanking.
module board_panel_ctrl #(
  parameter int NUM_SW         = 18,
  parameter int NUM_DIGITS     = 8,
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                    clock_50,
  input  logic                    resetn,
  input  logic [NUM_SW-1:0]       switch,
  input  logic [4*NUM_DIGITS-1:0] display_value,
  input  logic                    display_load,
  output logic [NUM_SW-1:0]       switch_db,
  output logic [NUM_SW-1:0]       switch_rise,
  output logic [6:0]              seven_seg_n [NUM_DIGITS-1:0],
  output logic [NUM_SW-1:0]       led_red,
  output logic [8:0]              led_green
);

  localparam int             PW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0]  PMAX     = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0]     STABLE_C = 4'(STABLE_SAMPLES);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [NUM_SW-1:0]       sync1_q, sync2_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    sample_tick;
  logic [3:0]              cnt_q [NUM_SW];
  logic [3:0]              cnt_d [NUM_SW];
  logic [NUM_SW-1:0]       db_q, db_d, db_prev_q, rise_q, rise_d;
  logic [7:0]              edge_cnt_q, edge_cnt_d;
  logic [7:0]              hb_cnt_q, hb_cnt_d;
  logic                    hb_q, hb_d;
  logic [4*NUM_DIGITS-1:0] held_q, held_d;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg_q [NUM_DIGITS-1:0];
  logic [6:0]              seg_d [NUM_DIGITS-1:0];

  assign sample_tick = (presc_q == PMAX);

  always_comb begin
    presc_d = sample_tick ? '0 : presc_q + 1'b1;
    db_d    = db_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample_tick) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] + 4'd1 == STABLE_C) begin
            db_d[i]  = ~db_q[i];
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = 4'd0;
        end
      end
    end
    // Rise pulse and edge count both land one edge after switch_db moves.
    rise_d     = db_q & ~db_prev_q;
    edge_cnt_d = (|rise_d) ? edge_cnt_q + 8'd1 : edge_cnt_q;
    hb_cnt_d   = sample_tick ? hb_cnt_q + 8'd1 : hb_cnt_q;
    hb_d       = (sample_tick && hb_cnt_q == 8'hFF) ? ~hb_q : hb_q;
    held_d     = display_load ? display_value : held_q;
  end

  always_comb begin
    blank = '0;
`ifdef BOARD_PANEL_LZ_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        lz       = lz & (held_q[4*i +: 4] == 4'h0);
        blank[i] = lz;
      end
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[i] = blank[i] ? 7'h7F : hex7(held_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      rise_q     <= '0;
      edge_cnt_q <= '0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      held_q     <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef BOARD_PANEL_LZ_BLANK_EN
        seg_q[i] <= (i == 0) ? 7'h40 : 7'h7F;
`else
        seg_q[i] <= 7'h40;
`endif
      end
    end else begin
      sync1_q    <= switch;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      rise_q     <= rise_d;
      edge_cnt_q <= edge_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      held_q     <= held_d;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign switch_db   = db_q;
  assign switch_rise = rise_q;
  assign led_red     = db_q;
  assign led_green   = {hb_q, edge_cnt_q};
  assign seven_seg_n = seg_q;

endmodule

// File: tb/tb_board_panel_ctrl.sv
// Randomised bench for board_panel_ctrl: switch-rise scoreboard against a tick-level
// debounce model, plus display decode and reset checks.
module tb_board_panel_ctrl;
  localparam int NSW  = 18;
  localparam int ND   = 8;
  localparam int SDIV = 4;
  localparam int STAB = 3;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NSW-1:0]  sw = '0;
  logic [4*ND-1:0] dval = '0;
  logic            dload = 1'b0;
  logic [NSW-1:0]  sdb, srise, lred;
  logic [6:0]      seg [ND-1:0];
  logic [8:0]      lg;
  logic [7*ND-1:0] seg_flat;

  board_panel_ctrl #(
    .NUM_SW(NSW), .NUM_DIGITS(ND), .SAMPLE_DIV(SDIV), .STABLE_SAMPLES(STAB)
  ) dut (
    .clock_50(clk), .resetn(resetn), .switch(sw),
    .display_value(dval), .display_load(dload),
    .switch_db(sdb), .switch_rise(srise), .seven_seg_n(seg),
    .led_red(lred), .led_green(lg)
  );

  always #10 clk = ~clk;

  always_comb begin
    for (int d = 0; d < ND; d++) seg_flat[7*d +: 7] = seg[d];
  end

  int compared = 0;
  int mismatched = 0;
  logic [8+NSW-1:0] exp_q[$];

  // Tick-level model state
  logic [NSW-1:0] mdb = '0;
  int             last_reset [NSW];
  int             tick_k = 0;
  logic [7:0]     mcount = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7*ND-1:0] exp_disp(input logic [4*ND-1:0] v);
    logic [6:0] hex [16];
    logic [7*ND-1:0] r;
    int msd;
    hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    msd = 0;
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < ND; i++) begin
      r[7*i +: 7] = hex[v[4*i +: 4]];
`ifdef BOARD_PANEL_LZ_BLANK_EN
      if (i > msd) r[7*i +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  // Hold a switch vector for one full sample period, then apply the debounce rule.
  task automatic tick_period(input logic [NSW-1:0] v);
    logic [NSW-1:0] old;
    sw = v;
    repeat (SDIV) @(posedge clk);
    #1;
    tick_k++;
    old = mdb;
    for (int i = 0; i < NSW; i++) begin
      if (v[i] == mdb[i]) last_reset[i] = tick_k;
      else if (tick_k - last_reset[i] >= STAB) begin
        mdb[i] = v[i];
        last_reset[i] = tick_k;
      end
    end
    if ((mdb & ~old) != '0) begin
      mcount = mcount + 8'd1;
      exp_q.push_back({mcount, mdb & ~old});
    end
    check("switch_db", 64'(sdb), 64'(mdb));
    check("led_red", 64'(lred), 64'(mdb));
    check("heartbeat", 64'(lg[8]), 64'((tick_k / 256) % 2));
  endtask

  task automatic disp_load(input logic [4*ND-1:0] v);
    @(negedge clk);
    dval = v;
    dload = 1'b1;
    @(negedge clk);
    dload = 1'b0;
    dval = $urandom;
    @(posedge clk);
    #1;
    check("display", 64'(seg_flat), 64'(exp_disp(v)));
    @(posedge clk);
    #1;
    check("display_hold", 64'(seg_flat), 64'(exp_disp(v)));
  endtask

  // Monitor: every cycle with a rise pulse must match the next expected event.
  always @(negedge clk) begin
    if (resetn && srise != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rise", 64'({lg[7:0], srise}), 64'(0));
      end else begin
        check("rise_event", 64'({lg[7:0], srise}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NSW-1:0] v;
    for (int i = 0; i < NSW; i++) last_reset[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", 64'(seg_flat), 64'(exp_disp('0)));
    check("reset_db", 64'(sdb), 64'(0));
    check("reset_rise", 64'(srise), 64'(0));
    check("reset_green", 64'(lg), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    fork
      begin
        v = '0;
        v[0] = 1'b1; v[5] = 1'b1;
        repeat (3) tick_period(v);
        v[3] = 1'b1; tick_period(v);
        tick_period(v);
        v[3] = 1'b0; tick_period(v);
        v[3] = 1'b1; repeat (3) tick_period(v);
        for (int t = 0; t < 1500; t++) begin
          v = v ^ NSW'($urandom & $urandom);
          tick_period(v);
        end
      end
      begin
        disp_load(32'h0000_00A5);
        disp_load(32'h0000_0000);
        disp_load(32'hFFFF_FFFF);
        for (int n = 0; n < 30; n++) disp_load(32'($urandom >> $urandom_range(0, 31)));
        disp_load(32'h1234_5678);
      end
    join

    repeat (SDIV + 2) tick_period('1);
    repeat (3) @(posedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    check("all_db_high", 64'(sdb), 64'({NSW{1'b1}}));

    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_seg", 64'(seg_flat), 64'(exp_disp('0)));
    check("async_reset_db", 64'(sdb), 64'(0));
    check("async_reset_red", 64'(lred), 64'(0));
    check("async_reset_rise", 64'(srise), 64'(0));
    check("async_reset_green", 64'(lg), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_db", 64'(sdb), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
